melody_arbiter: RTL
===================

Name: melody_arbiter

Overview:
- Shares the single 4-bit note output path (note code feeding the tone generator/buzzer) between N_SRC melody sequencer blocks.
- Each sequencer raises a request while it wants to play. The arbiter grants one source at a time in round-robin order and forwards that source's note code.
- Enforces a maximum play length and an inter-melody silence gap, both timed in beat ticks from an internal prescaler.

Parameters:
N_SRC, 4, number of requesting melody sources (2..8)
TICK_DIV, 12_500_000, clk cycles per beat tick (>=2)
MAX_TICKS, 256, beat ticks a grant may last before forced release (>=1)
GAP_TICKS, 2, beat ticks of enforced silence after each grant (>=0)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, active-low
src_req  input  N_SRC  per-source play request, level
src_note  input  4*N_SRC  per-source note code; source i on bits [4i+3:4i]; 0 = silence
src_grant  output  N_SRC  one-hot grant, registered
note_out  output  4  forwarded note code to tone generator, registered
grant_id  output  $clog2(N_SRC)  index of current/last granted source
busy  output  1  high in PLAY or GAP
timeout  output  1  one-cycle pulse on forced release

Behaviour:
- One clock, clk; reset is asynchronous and active-low (rst_n).
- Reset values:
  - state=IDLE; src_grant=0; note_out=0; busy=0; timeout=0; grant_id=0.
  - Prescaler=0; play/gap counters=0; lockout mask=0.
  - RR pointer last=N_SRC-1, so source 0 has first priority.
- Reset mid-operation aborts immediately and note_out drops to 0 asynchronously.
- Prescaler: free-running 0..TICK_DIV-1. tick=1 for one cycle when count==TICK_DIV-1, then wraps to 0. It is not reset by FSM activity.
- Eligible vector: elig = src_req & ~lockout.
- IDLE:
  - note_out=0, src_grant=0.
  - If elig!=0, pick the first set bit scanning last+1, last+2, ... (mod N_SRC).
  - Next edge: state=PLAY, src_grant=onehot(winner), grant_id=winner, last=winner, play_cnt=0.
- PLAY:
  - Each cycle note_out <= src_note[grant_id], giving one cycle of latency from input to output. The first forwarded note appears the cycle after src_grant rises.
  - Release when src_req[grant_id]==0 (normal release), or when tick && play_cnt==MAX_TICKS-1 (forced release).
  - play_cnt increments on each tick.
  - On release: next edge state=GAP, src_grant=0, note_out=0, gap_cnt=0.
  - Forced release additionally pulses timeout for 1 cycle and sets lockout[grant_id].
  - If both release conditions occur in the same cycle, it is a normal release: no timeout, no lockout.
  - If the winner drops src_req on the grant cycle, PLAY sees it low, releases after one cycle, and a single 0/garbage-free note_out cycle is allowed.
- GAP:
  - note_out=0, src_grant=0, busy=1.
  - Exit to IDLE on tick && gap_cnt==GAP_TICKS-1; gap_cnt increments on tick.
  - With GAP_TICKS=0, GAP lasts exactly one cycle.
- Lockout: lockout[i] clears in any cycle where src_req[i]==0. A timed-out source must drop and re-raise its request to be eligible again.
- busy = (state!=IDLE).
- Requests arriving during PLAY/GAP wait. There is no preemption.
- Width rules:
  - play_cnt is $clog2(MAX_TICKS+1) bits; gap_cnt is $clog2(GAP_TICKS+1) bits (min 1); prescaler is $clog2(TICK_DIV) bits.
  - No counter ever exceeds its terminal value.
- Unused src_note bits of non-granted sources are ignored.

Test Plan:
(Bench params: N_SRC=4, TICK_DIV=4, MAX_TICKS=3, GAP_TICKS=1.)
- Reset: hold rst_n=0 with src_req=4'b1111 -> all outputs 0. Release -> src_grant=4'b0001 two edges later (IDLE sample, then register). note_out=src_note[0] one cycle after that.
- Round-robin: src_req=4'b1011 held, each source drops req 5 cycles after its grant then re-raises it -> grant order 0,1,3,0,1. Exactly one tick-aligned GAP of silence (note_out=0) between grants.
- Note forwarding: granted source 2 steps src_note[11:8] through 7,8,2 on consecutive cycles -> note_out shows 7,8,2 each delayed one cycle; other sources' notes never appear.
- Timeout: source 1 holds req for 40 cycles -> forced release on the 3rd tick of PLAY, one-cycle timeout pulse, then GAP. Source 1 is not regranted until it drops req; source 2 (requesting) is granted next.
- Simultaneous: source 0's req falls on the same cycle as the MAX_TICKS terminal tick -> timeout stays 0, no lockout, and source 0 is regranted after GAP if it re-raises.
- Async reset mid-PLAY: drop rst_n between clock edges while note_out=9 -> note_out=0 and src_grant=0 immediately. After release, source 0 has priority again.

Source files
------------

// File: rtl/melody_arbiter.sv
// melody_arbiter: round-robin owner of the shared 4-bit note path.
//
// Each melody sequencer raises src_req while it wants to play. One source
// at a time is granted and its note code is forwarded (one cycle late) to
// the tone generator. A grant is cut short after MAX_TICKS beat ticks, and
// every grant is followed by GAP_TICKS beat ticks of silence.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   src_req    per-source play request (level)
//   src_note   per-source note code, source i on [4i+3:4i], 0 = silence
//   src_grant  one-hot grant (registered)
//   note_out   forwarded note code (registered)
//   grant_id   index of the current / most recent granted source
//   busy       high while playing or in the silence gap
//   timeout    one-cycle pulse when a grant is force-released
module melody_arbiter #(
    parameter int unsigned N_SRC     = 4,
    parameter int unsigned TICK_DIV  = 12_500_000,
    parameter int unsigned MAX_TICKS = 256,
    parameter int unsigned GAP_TICKS = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_SRC-1:0]         src_req,
    input  logic [4*N_SRC-1:0]       src_note,
    output logic [N_SRC-1:0]         src_grant,
    output logic [3:0]               note_out,
    output logic [$clog2(N_SRC)-1:0] grant_id,
    output logic                     busy,
    output logic                     timeout
);

    localparam int unsigned IdW   = $clog2(N_SRC);
    localparam int unsigned PresW = $clog2(TICK_DIV);
    localparam int unsigned PlayW = $clog2(MAX_TICKS + 1);
    localparam int unsigned GapW  = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

    localparam logic [PresW-1:0] PresLast = PresW'(TICK_DIV - 1);
    localparam logic [PlayW-1:0] PlayLast = PlayW'(MAX_TICKS - 1);
    // Only meaningful when GAP_TICKS > 0; the zero case bypasses the counter.
    localparam logic [GapW-1:0]  GapLast  = GapW'(GAP_TICKS - 1);

    typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

    state_e             state_q, state_d;
    logic [PresW-1:0]   presc_q;
    logic [PlayW-1:0]   play_q, play_d;
    logic [GapW-1:0]    gap_q, gap_d;
    logic [N_SRC-1:0]   lock_q, lock_d;
    logic [IdW-1:0]     last_q, last_d;
    logic [IdW-1:0]     id_q, id_d;
    logic [N_SRC-1:0]   grant_q, grant_d;
    logic [3:0]         note_q, note_d;
    logic               timeout_q, timeout_d;

    logic               tick;
    logic [N_SRC-1:0]   elig;
    logic               found;
    logic [IdW-1:0]     winner;
    logic [31:0]        idx;
    logic [3:0]         sel_note;
    logic               owner_req;

    // Free-running beat prescaler, independent of arbitration activity.
    assign tick = (presc_q == PresLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PresW'(1);
        end
    end

    assign elig = src_req & ~lock_q;

    // Round-robin search starting just after the last winner.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned k = 1; k <= N_SRC; k++) begin
            idx = (32'(last_q) + k) % N_SRC;
            if (!found && elig[idx[IdW-1:0]]) begin
                found  = 1'b1;
                winner = idx[IdW-1:0];
            end
        end
    end

    always_comb begin
        sel_note = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (id_q == IdW'(i)) begin
                sel_note = src_note[4*i +: 4];
            end
        end
    end

    // grant_q is one-hot on the owner while playing.
    assign owner_req = |(src_req & grant_q);

    always_comb begin
        state_d   = state_q;
        grant_d   = '0;
        note_d    = '0;
        id_d      = id_q;
        last_d    = last_q;
        play_d    = play_q;
        gap_d     = gap_q;
        timeout_d = 1'b0;
        // A source that lets go of its request is forgiven its timeout.
        lock_d    = lock_q & src_req;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d         = StPlay;
                    grant_d[winner] = 1'b1;
                    id_d            = winner;
                    last_d          = winner;
                    play_d          = '0;
                end
            end
            StPlay: begin
                if (!owner_req) begin
                    // Normal release wins even on the terminal tick.
                    state_d = StGap;
                    gap_d   = '0;
                end else if (tick && (play_q == PlayLast)) begin
                    state_d   = StGap;
                    gap_d     = '0;
                    timeout_d = 1'b1;
                    lock_d    = lock_d | grant_q;
                end else begin
                    grant_d = grant_q;
                    note_d  = sel_note;
                    if (tick) begin
                        play_d = play_q + PlayW'(1);
                    end
                end
            end
            StGap: begin
                if ((GAP_TICKS == 0) || (tick && (gap_q == GapLast))) begin
                    state_d = StIdle;
                end else if (tick) begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            play_q    <= '0;
            gap_q     <= '0;
            lock_q    <= '0;
            last_q    <= IdW'(N_SRC - 1);
            id_q      <= '0;
            grant_q   <= '0;
            note_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            play_q    <= play_d;
            gap_q     <= gap_d;
            lock_q    <= lock_d;
            last_q    <= last_d;
            id_q      <= id_d;
            grant_q   <= grant_d;
            note_q    <= note_d;
            timeout_q <= timeout_d;
        end
    end

    assign src_grant = grant_q;
    assign note_out  = note_q;
    assign grant_id  = id_q;
    assign busy      = (state_q != StIdle);
    assign timeout   = timeout_q;

endmodule
